// File: rtl/light_hash_stream_if.sv
// Beat stream into the hash engine: valid/ready handshake carrying one DATA_W beat.
interface light_hash_stream_if #(
   parameter int unsigned DATA_W = 8
);
   logic              M_valid;
   logic              M_ready;
   logic [DATA_W-1:0] M;

   modport master (output M_valid, output M, input M_ready);
   modport slave  (input M_valid, input M, output M_ready);
endinterface

// File: rtl/light_hash_stream.sv
// Feistel-based streaming hash: absorbs a length-prefixed byte message, then
// strengthens with the length bytes and holds the digest until the next start.
module light_hash_stream #(
   parameter int unsigned         DATA_W   = 8,
   parameter int unsigned         DIGEST_W = 32,
   parameter int unsigned         ROUNDS   = 4,
   parameter int unsigned         LEN_W    = 64,
   parameter logic [DIGEST_W-1:0] IV       = DIGEST_W'(32'h6A09E667)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LEN_W-1:0]    input_length,
   light_hash_stream_if.slave  m,
   output logic                busy,
   output logic                hash_ready,
   output logic [DIGEST_W-1:0] digest
);
   localparam int unsigned BYTES   = DATA_W / 8;
   localparam int unsigned LBYTES  = LEN_W / 8;
   localparam int unsigned H       = DIGEST_W / 2;
   localparam int unsigned CNT_MAX = (BYTES > LBYTES) ? BYTES : LBYTES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
      $error("DATA_W must be a non-zero multiple of 8");
   end
   if ((DIGEST_W % 16) != 0 || DIGEST_W == 0) begin : g_bad_digest_w
      $error("DIGEST_W must be a non-zero multiple of 16");
   end
   if ((LEN_W % 8) != 0 || LEN_W == 0) begin : g_bad_len_w
      $error("LEN_W must be a non-zero multiple of 8");
   end
   if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
      $error("ROUNDS must be in 1..255");
   end

   typedef enum logic [2:0] {IDLE, ABSORB, ROUND, LENPAD, DONE} state_t;

   state_t              state_q, state_d;
   logic [DIGEST_W-1:0] s_q, s_d, s_rnd, digest_d;
   logic [LEN_W-1:0]    len_q, len_d, bytes_left_q, bytes_left_d;
   logic [DATA_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, nb_c;
   logic [7:0]          rnd_q, rnd_d, k_c;
   logic                m_ready_q, m_ready_d, busy_d, hash_ready_d;
   logic                last_round_c, last_byte_c;

   // One Feistel round: L' = R, R' = L ^ (rotl(R,3) ^ (R + k replicated))
   function automatic logic [DIGEST_W-1:0] round_f(input logic [DIGEST_W-1:0] s,
                                                   input logic [7:0]          k);
      logic [H-1:0] l, r, f;
      l = s[DIGEST_W-1:H];
      r = s[H-1:0];
      f = {r[H-4:0], r[H-1:H-3]} ^ H'(r + {(H/8){k}});
      return {r, l ^ f};
   endfunction

   // Round datapath: the beat shifts out MSB byte first, the length LSB byte first
   always_comb begin
      k_c          = (state_q == LENPAD) ? len_q[7:0] : beat_q[DATA_W-1 -: 8];
      s_rnd        = round_f(s_q, k_c ^ rnd_q);
      last_round_c = (rnd_q == 8'(ROUNDS - 1));
      last_byte_c  = (cnt_q == CNT_W'(1));
      nb_c         = (bytes_left_q < LEN_W'(BYTES)) ? CNT_W'(bytes_left_q) : CNT_W'(BYTES);
   end

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      len_d        = len_q;
      bytes_left_d = bytes_left_q;
      beat_d       = beat_q;
      cnt_d        = cnt_q;
      rnd_d        = rnd_q;
      hash_ready_d = hash_ready;
      digest_d     = digest;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               len_d        = input_length;
               bytes_left_d = input_length;
               s_d          = IV;
               rnd_d        = 8'd0;
               hash_ready_d = 1'b0;
               if (input_length != '0) begin
                  state_d = ABSORB;
               end else begin
                  state_d = LENPAD;
                  cnt_d   = CNT_W'(LBYTES);
               end
            end
         end
         ABSORB: begin
            if (m.M_valid) begin
               beat_d       = m.M;
               cnt_d        = nb_c;
               bytes_left_d = bytes_left_q - LEN_W'(nb_c);
               rnd_d        = 8'd0;
               state_d      = ROUND;
            end
         end
         ROUND: begin
            s_d   = s_rnd;
            rnd_d = rnd_q + 8'd1;
            if (last_round_c) begin
               rnd_d  = 8'd0;
               beat_d = beat_q << 8;
               cnt_d  = cnt_q - CNT_W'(1);
               if (last_byte_c) begin
                  if (bytes_left_q != '0) begin
                     state_d = ABSORB;
                  end else begin
                     state_d = LENPAD;
                     cnt_d   = CNT_W'(LBYTES);
                  end
               end
            end
         end
         LENPAD: begin
            s_d   = s_rnd;
            rnd_d = rnd_q + 8'd1;
            if (last_round_c) begin
               rnd_d = 8'd0;
               len_d = len_q >> 8;
               cnt_d = cnt_q - CNT_W'(1);
               if (last_byte_c) begin
                  digest_d     = s_rnd;
                  hash_ready_d = 1'b1;
                  state_d      = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      m_ready_d = (state_d == ABSORB);
      busy_d    = (state_d == ABSORB) || (state_d == ROUND) || (state_d == LENPAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         s_q          <= IV;
         len_q        <= '0;
         bytes_left_q <= '0;
         beat_q       <= '0;
         cnt_q        <= '0;
         rnd_q        <= '0;
         m_ready_q    <= 1'b0;
         busy         <= 1'b0;
         hash_ready   <= 1'b0;
         digest       <= '0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         len_q        <= len_d;
         bytes_left_q <= bytes_left_d;
         beat_q       <= beat_d;
         cnt_q        <= cnt_d;
         rnd_q        <= rnd_d;
         m_ready_q    <= m_ready_d;
         busy         <= busy_d;
         hash_ready   <= hash_ready_d;
         digest       <= digest_d;
      end
   end

   assign m.M_ready = m_ready_q;
endmodule
